// File: rtl/imm_field_packer_if.sv
// imm_field_packer_if: load-side and instruction-memory-side handshakes for the immediate field packer
interface imm_field_packer_if #(parameter int DATA_W = 8, parameter int FIELD_W = 2);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              flush_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_word;
  logic [2:0]        out_fields;
  logic              range_err;
  logic              err_clr;
  modport master (
    output in_valid, in_data, flush, out_ready, err_clr,
    input  in_ready, flush_done, out_valid, out_word, out_fields, range_err
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready, err_clr,
    output in_ready, flush_done, out_valid, out_word, out_fields, range_err
  );
endinterface

// File: rtl/imm_field_packer.sv
// imm_field_packer: narrows signed immediates to FIELD_W-bit fields and packs them into DATA_W-bit words
// Define SATURATE_EN to clamp out-of-range values instead of truncating them.
module imm_field_packer #(
  parameter int DATA_W  = 8,
  parameter int FIELD_W = 2
) (
  input logic            clk,
  input logic            rst_n,
  imm_field_packer_if.slave bus
);
  localparam int FIELDS = DATA_W / FIELD_W;
  localparam int CW     = $clog2(FIELDS + 1);
  logic [CW-1:0]      count, held;
  logic [DATA_W-1:0]  acc, acc_next;
  logic [FIELD_W-1:0] fld;
  logic               slot_free, last, in_fire, fits, flush_go, load;
  assign slot_free   = !bus.out_valid | bus.out_ready;
  assign last        = count == CW'(FIELDS - 1);
  assign bus.in_ready = !last | slot_free;
  assign in_fire     = bus.in_valid & bus.in_ready;
  assign fits        = (&bus.in_data[DATA_W-1:FIELD_W-1]) | ~(|bus.in_data[DATA_W-1:FIELD_W-1]);
  assign held        = count + CW'(in_fire);
  // The cycle after flush_done the source may still show flush; that is the tail of the same request.
  assign flush_go    = bus.flush & !bus.flush_done & slot_free;
  assign load        = (in_fire & last) | (flush_go & (held != '0));
  always_comb begin
`ifdef SATURATE_EN
    fld = fits ? bus.in_data[FIELD_W-1:0]
        : bus.in_data[DATA_W-1] ? {1'b1, {(FIELD_W-1){1'b0}}} : {1'b0, {(FIELD_W-1){1'b1}}};
`else
    fld = bus.in_data[FIELD_W-1:0];
`endif
  end
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < FIELDS; k++)
      if (in_fire && count == CW'(k)) acc_next[k*FIELD_W +: FIELD_W] = fld;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count          <= '0;
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_word   <= '0;
      bus.out_fields <= '0;
      bus.range_err  <= 1'b0;
      bus.flush_done <= 1'b0;
    end else begin
      count          <= load ? '0 : held;
      acc            <= load ? '0 : acc_next;
      bus.range_err  <= (in_fire & !fits) | (bus.range_err & !bus.err_clr);
      bus.flush_done <= flush_go;
      if (load) begin
        bus.out_valid  <= 1'b1;
        bus.out_word   <= acc_next;
        bus.out_fields <= 3'(held);
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imm_field_packer.sv
// tb_imm_field_packer: directed and random stimulus against a field-queue reference model
module tb_imm_field_packer;
  localparam int DW = 8, FW = 2, F = DW / FW;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  imm_field_packer_if #(.DATA_W(DW), .FIELD_W(FW)) bus();
  imm_field_packer #(.DATA_W(DW), .FIELD_W(FW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0, bad = 0;
  int pend[$];
  bit m_ov, m_err, m_fd;
  int m_word, m_fields;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic bit fits(int v8);
    int sv = v8 >= 128 ? v8 - 256 : v8;
    return sv >= -(1 << (FW-1)) && sv <= (1 << (FW-1)) - 1;
  endfunction
  function automatic int narrow(int v8);
    int sv = v8 >= 128 ? v8 - 256 : v8;
    int mask = (1 << FW) - 1;
    if (fits(v8)) return sv & mask;
`ifdef SATURATE_EN
    return sv < 0 ? (-(1 << (FW-1))) & mask : (1 << (FW-1)) - 1;
`else
    return v8 & mask;
`endif
  endfunction
  task automatic cyc(bit v, int d, bit f, bit r, bit c);
    bit slot, rdy, fire, fd_n, err_n;
    bus.in_valid = v; bus.in_data = d[DW-1:0]; bus.flush = f; bus.out_ready = r; bus.err_clr = c;
    @(negedge clk);
    slot = !m_ov || r;
    rdy  = pend.size() != F-1 || slot;
    chk("in_ready",   bus.in_ready,   rdy);
    chk("out_valid",  bus.out_valid,  m_ov);
    chk("out_word",   bus.out_word,   m_word);
    chk("out_fields", bus.out_fields, m_fields);
    chk("range_err",  bus.range_err,  m_err);
    chk("flush_done", bus.flush_done, m_fd);
    fire  = v && rdy;
    fd_n  = f && !m_fd && slot;
    err_n = (fire && !fits(d & 255)) || (m_err && !c);
    if (fire) pend.push_back(narrow(d & 255));
    if ((fire && pend.size() == F) || (fd_n && pend.size() > 0)) begin
      m_word = 0;
      foreach (pend[i]) m_word += pend[i] << (i*FW);
      m_fields = pend.size();
      m_ov = 1;
      pend.delete();
    end else if (r) m_ov = 0;
    m_err = err_n;
    m_fd  = fd_n;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    bus.in_valid = 0; bus.flush = 0; bus.err_clr = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_valid",  bus.out_valid,  0);
    chk("rst_word",   bus.out_word,   0);
    chk("rst_fields", bus.out_fields, 0);
    chk("rst_err",    bus.range_err,  0);
    chk("rst_fdone",  bus.flush_done, 0);
    pend.delete();
    m_ov = 0; m_err = 0; m_fd = 0; m_word = 0; m_fields = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  initial begin
    logic [DW-1:0] held_word;
    bus.in_valid = 0; bus.in_data = 0; bus.flush = 0; bus.out_ready = 0; bus.err_clr = 0;
    do_reset();
    cyc(1, 'h01, 0, 1, 0); cyc(1, 'hFF, 0, 1, 0); cyc(1, 'hFE, 0, 1, 0); cyc(1, 'h00, 0, 1, 0);
    chk("t1_word", bus.out_word, 'h2D);
    chk("t1_fields", bus.out_fields, 4);
    chk("t1_err", bus.range_err, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 'h01, 0, 1, 0); cyc(1, 'hFE, 0, 1, 0); cyc(0, 0, 1, 1, 0);
    chk("t2_word", bus.out_word, 'h09);
    chk("t2_fields", bus.out_fields, 2);
    chk("t2_fdone", bus.flush_done, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 'h06, 0, 1, 0); cyc(1, 'hF9, 0, 1, 0); cyc(0, 0, 1, 1, 0);
    chk("t3_err", bus.range_err, 1);
`ifdef SATURATE_EN
    chk("t3_word", bus.out_word, 'h09);
`else
    chk("t3_word", bus.out_word, 'h06);
`endif
    cyc(0, 0, 0, 1, 1);
    chk("t3_clr", bus.range_err, 0);
    for (int i = 0; i < 4; i++) cyc(1, 'h01, 0, 0, 0);
    held_word = bus.out_word;
    chk("t4_first", held_word, 'h55);
    cyc(1, 'hFF, 0, 0, 0); cyc(1, 'hFF, 0, 0, 0); cyc(1, 'h00, 0, 0, 0);
    bus.in_valid = 1; bus.in_data = 'h01; bus.out_ready = 0;
    #1;
    chk("t4_stall", bus.in_ready, 0);
    chk("t4_stable", bus.out_word, held_word);
    cyc(1, 'h01, 0, 1, 0);
    chk("t4_next_valid", bus.out_valid, 1);
    chk("t4_next_word", bus.out_word, 'h4F);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 'h40, 0, 1, 1);
    chk("t5_setwins", bus.range_err, 1);
    cyc(0, 0, 0, 1, 1);
    chk("t5_clr", bus.range_err, 0);
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0);
    cyc(1, 'h01, 0, 1, 0); cyc(1, 'h01, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 'hFE, 0, 1, 0);
    chk("t6_word", bus.out_word, 'hAA);
    chk("t6_fields", bus.out_fields, 4);
    for (int n = 0; n < 400; n++) begin
      int d;
      d = $urandom_range(0, 1) ? int'($urandom_range(0, 255)) : (int'($urandom_range(0, 3)) - 2) & 255;
      cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
